// File: rtl/ccw_rx.sv
// ccw_rx: slave-side receiver for the control-command-word (CCW) message.
// Frame layout on the byte stream: MARKER, FLAG, N1, N2, payload[{N1,N2}].
// The header is validated, payload bytes are delivered with a one-cycle
// strobe, and message boundaries and framing errors are reported.
// Marker/flag values come from MARKER_MASTER / FLAG_CONTROL_COMMAND_WORD
// (normally provided by msg_defs.vh); fallbacks keep this file standalone.
// Optional feature: define CCW_RX_ERR_CNT_EN to add a saturating err_cnt port.

`ifndef MARKER_MASTER
`define MARKER_MASTER 8'hF0
`endif
`ifndef FLAG_CONTROL_COMMAND_WORD
`define FLAG_CONTROL_COMMAND_WORD 8'h01
`endif

module ccw_rx #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] d,
  input  logic       d_rdy,
  output logic [7:0] q,
  output logic       q_rdy,
  output logic       msg_start,
  output logic       msg_end,
  output logic       msg_err,
  output logic [1:0] err_code,
  output logic       rx_active
`ifdef CCW_RX_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FLAG,
    N1,
    N2,
    PAYLOAD
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_FLAG = 2'd1,
    ERR_BAD_LEN  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  localparam logic [7:0]      MARKER    = `MARKER_MASTER;
  localparam logic [7:0]      FLAG_CCW  = `FLAG_CONTROL_COMMAND_WORD;
  localparam logic [15:0]     MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  state_e          state;
  state_e          state_next;

  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [15:0]     cnt;
  logic [TO_W-1:0] gap;

  logic [15:0]     len_w;
  logic [15:0]     cnt_inc;
  logic            timeout_hit;
  logic            len_hi_load;
  logic            len_load;
  logic            start_set;
  logic            pay_set;
  logic            end_set;
  logic            err_set;
  err_e            err_val;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and single-cycle control strobes.
  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_next  = state;
    len_hi_load = 1'b0;
    len_load    = 1'b0;
    start_set   = 1'b0;
    pay_set     = 1'b0;
    end_set     = 1'b0;
    err_set     = 1'b0;
    err_val     = ERR_NONE;
    len_w       = {len_hi, d};
    cnt_inc     = cnt + 16'd1;
    timeout_hit = (state != IDLE) && !d_rdy && (gap == TO_LAST);

    if (d_rdy) begin
      case (state)
        IDLE: begin
          if (d == MARKER) begin
            state_next = FLAG;
          end
        end
        FLAG: begin
          if (d == FLAG_CCW) begin
            state_next = N1;
          end else begin
            err_set    = 1'b1;
            err_val    = ERR_BAD_FLAG;
            state_next = IDLE;
          end
        end
        N1: begin
          len_hi_load = 1'b1;
          state_next  = N2;
        end
        N2: begin
          if ((len_w == 16'd0) || (len_w > MAX_LEN_W)) begin
            err_set    = 1'b1;
            err_val    = ERR_BAD_LEN;
            state_next = IDLE;
          end else begin
            len_load   = 1'b1;
            start_set  = 1'b1;
            state_next = PAYLOAD;
          end
        end
        PAYLOAD: begin
          pay_set = 1'b1;
          if (cnt_inc == len) begin
            end_set    = 1'b1;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end else if (timeout_hit) begin
      err_set    = 1'b1;
      err_val    = ERR_TIMEOUT;
      state_next = IDLE;
    end
  end

  // Registered outputs, header length capture and payload byte counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q         <= '0;
      q_rdy     <= 1'b0;
      msg_start <= 1'b0;
      msg_end   <= 1'b0;
      msg_err   <= 1'b0;
      err_code  <= '0;
      len_hi    <= '0;
      len       <= '0;
      cnt       <= '0;
    end else begin
      q_rdy     <= pay_set;
      msg_start <= start_set;
      msg_end   <= end_set;
      msg_err   <= err_set;
      if (err_set) begin
        err_code <= err_val;
      end
      if (pay_set) begin
        q <= d;
      end
      if (len_hi_load) begin
        len_hi <= d;
      end
      if (len_load) begin
        len <= len_w;
      end
      if (state_next != PAYLOAD) begin
        cnt <= '0;
      end else if (pay_set) begin
        cnt <= cnt_inc;
      end
    end
  end

  // Inter-byte gap counter: runs only while a message is in progress
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gap <= '0;
    end else if (d_rdy || (state == IDLE) || (state_next == IDLE)) begin
      gap <= '0;
    end else begin
      gap <= gap + 1'b1;
    end
  end

  assign rx_active = (state != IDLE);

`ifdef CCW_RX_ERR_CNT_EN
  // Saturating count of aborted messages, cleared only by reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_cnt <= '0;
    end else if (err_set && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ccw_rx.sv
// Directed testbench for ccw_rx (default parameters, MARKER=F0, FLAG=01).
// Inputs change on the falling edge; outputs are read on the falling edge
// or 1 ns after the rising edge.
module tb_ccw_rx;

  localparam logic [7:0] MK = 8'hF0;
  localparam logic [7:0] FL = 8'h01;
  localparam int         TO = 1024;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [7:0] d = 8'h00;
  logic       d_rdy = 1'b0;
  logic [7:0] q;
  logic       q_rdy;
  logic       msg_start;
  logic       msg_end;
  logic       msg_err;
  logic [1:0] err_code;
  logic       rx_active;
`ifdef CCW_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  ccw_rx #(.MAX_LEN(16), .TIMEOUT(1024), .TO_W(11)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .d         (d),
    .d_rdy     (d_rdy),
    .q         (q),
    .q_rdy     (q_rdy),
    .msg_start (msg_start),
    .msg_end   (msg_end),
    .msg_err   (msg_err),
    .err_code  (err_code),
    .rx_active (rx_active)
`ifdef CCW_RX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int         mon_start = 0;
  int         mon_end = 0;
  int         mon_err = 0;
  int         mon_end_lone = 0;
  logic [7:0] end_q = 8'h00;
  logic [7:0] q_log[$];

  // Event log of output pulses, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (n_rst) begin
      if (q_rdy) q_log.push_back(q);
      if (msg_start) mon_start++;
      if (msg_end) begin
        mon_end++;
        end_q = q;
        if (!q_rdy) mon_end_lone++;
      end
      if (msg_err) mon_err++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    mon_start = 0;
    mon_end = 0;
    mon_err = 0;
    mon_end_lone = 0;
    q_log.delete();
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    d = b;
    d_rdy = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      d_rdy = 1'b0;
      d = 8'h00;
    end
  endtask

  task automatic test_reset();
    #2;
    n_rst = 1'b0;
    d = MK;
    d_rdy = 1'b1;
    idle(3);
    n_cmp++;
    if ({q, q_rdy, msg_start, msg_end, msg_err, err_code, rx_active} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {q, q_rdy, msg_start, msg_end, msg_err, err_code, rx_active});
    end
    @(negedge clk);
    n_rst = 1'b1;
    idle(2);
    n_cmp++;
    if (rx_active !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: rx_active got %b want 0", rx_active);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b[3];
    exp_b = '{8'hAA, 8'h55, 8'hC3};
    clr();
    send(MK); send(FL); send(8'h00); send(8'h03);
    send(8'hAA);
    n_cmp++;
    if ({msg_start, q_rdy} !== 2'b10) begin
      n_bad++;
      $display("FAIL basic_start: got start,q_rdy=%b want 10", {msg_start, q_rdy});
    end
    send(8'h55);
    n_cmp++;
    if ({q_rdy, q} !== {1'b1, 8'hAA}) begin
      n_bad++;
      $display("FAIL basic_latency: got q_rdy=%b q=%h want 1 AA", q_rdy, q);
    end
    send(8'hC3);
    idle(1);
    n_cmp++;
    if ({q_rdy, msg_end, q, rx_active} !== {1'b1, 1'b1, 8'hC3, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_end: got q_rdy=%b end=%b q=%h act=%b want 1 1 C3 0",
               q_rdy, msg_end, q, rx_active);
    end
    idle(3);
    n_cmp++;
    if ({q_rdy, q} !== {1'b0, 8'hC3}) begin
      n_bad++;
      $display("FAIL basic_hold: got q_rdy=%b q=%h want 0 C3", q_rdy, q);
    end
    n_cmp++;
    if (q_log.size() != 3) begin
      n_bad++;
      $display("FAIL basic_count: got %0d bytes want 3", q_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (q_log[i] !== exp_b[i]) begin
          n_bad++;
          $display("FAIL basic_byte%0d: got %h want %h", i, q_log[i], exp_b[i]);
        end
      end
    end
    n_cmp++;
    if ({mon_start, mon_end, mon_err, mon_end_lone} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL basic_pulses: start=%0d end=%0d err=%0d lone_end=%0d want 1 1 0 0",
               mon_start, mon_end, mon_err, mon_end_lone);
    end
    n_cmp++;
    if (err_code !== 2'd0) begin
      n_bad++;
      $display("FAIL basic_err_code: got %0d want 0", err_code);
    end
  endtask

  task automatic test_noise();
    clr();
    send(8'h12); send(8'h34);
    send(MK); send(FL); send(8'h00); send(8'h01); send(8'h7E);
    idle(1);
    n_cmp++;
    if ({msg_end, q_rdy, q} !== {1'b1, 1'b1, 8'h7E}) begin
      n_bad++;
      $display("FAIL noise_end: got end=%b q_rdy=%b q=%h want 1 1 7E", msg_end, q_rdy, q);
    end
    idle(2);
    n_cmp++;
    if ({mon_err, mon_start, mon_end} !== {32'd0, 32'd1, 32'd1} || q_log.size() != 1) begin
      n_bad++;
      $display("FAIL noise_pulses: err=%0d start=%0d end=%0d bytes=%0d want 0 1 1 1",
               mon_err, mon_start, mon_end, q_log.size());
    end
  endtask

  task automatic test_bad_flag();
    clr();
    send(MK); send(8'h00);
    idle(1);
    n_cmp++;
    if ({msg_err, err_code, rx_active} !== {1'b1, 2'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL badflag_err: got err=%b code=%0d act=%b want 1 1 0",
               msg_err, err_code, rx_active);
    end
    idle(1);
    n_cmp++;
    if ({msg_err, err_code} !== {1'b0, 2'd1}) begin
      n_bad++;
      $display("FAIL badflag_pulse: got err=%b code=%0d want 0 1", msg_err, err_code);
    end
    send(MK); send(FL); send(8'h00); send(8'h02); send(8'h11); send(8'h22);
    idle(2);
    n_cmp++;
    if (q_log.size() != 2 || mon_end != 1 || mon_err != 1) begin
      n_bad++;
      $display("FAIL badflag_recover: bytes=%0d end=%0d err=%0d want 2 1 1",
               q_log.size(), mon_end, mon_err);
    end else begin
      n_cmp++;
      if ({q_log[0], q_log[1]} !== 16'h1122) begin
        n_bad++;
        $display("FAIL badflag_bytes: got %h%h want 1122", q_log[0], q_log[1]);
      end
    end
    send(MK); send(MK);
    idle(1);
    n_cmp++;
    if ({msg_err, err_code, rx_active} !== {1'b1, 2'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL badflag_remarker: got err=%b code=%0d act=%b want 1 1 0",
               msg_err, err_code, rx_active);
    end
    idle(2);
  endtask

  task automatic test_bad_len();
    clr();
    send(MK); send(FL); send(8'h00); send(8'h00);
    idle(1);
    n_cmp++;
    if ({msg_err, err_code, rx_active} !== {1'b1, 2'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL badlen_zero: got err=%b code=%0d act=%b want 1 2 0",
               msg_err, err_code, rx_active);
    end
    idle(1);
    send(MK); send(FL); send(8'h00); send(8'h11);
    idle(1);
    n_cmp++;
    if ({msg_err, err_code} !== {1'b1, 2'd2}) begin
      n_bad++;
      $display("FAIL badlen_17: got err=%b code=%0d want 1 2", msg_err, err_code);
    end
    send(MK); send(FL); send(8'h01); send(8'h00);
    idle(1);
    n_cmp++;
    if ({msg_err, err_code} !== {1'b1, 2'd2}) begin
      n_bad++;
      $display("FAIL badlen_256: got err=%b code=%0d want 1 2", msg_err, err_code);
    end
    idle(2);
    n_cmp++;
    if (mon_start != 0 || q_log.size() != 0 || mon_err != 3) begin
      n_bad++;
      $display("FAIL badlen_quiet: start=%0d bytes=%0d err=%0d want 0 0 3",
               mon_start, q_log.size(), mon_err);
    end
    clr();
    send(MK); send(FL); send(8'h00); send(8'h10);
    for (int i = 1; i <= 16; i++) send(8'(i));
    idle(3);
    n_cmp++;
    if (q_log.size() != 16 || mon_end != 1 || mon_start != 1 || mon_err != 0 || end_q !== 8'h10) begin
      n_bad++;
      $display("FAIL maxlen_msg: bytes=%0d end=%0d start=%0d err=%0d last=%h want 16 1 1 0 10",
               q_log.size(), mon_end, mon_start, mon_err, end_q);
    end
  endtask

  task automatic test_timeout();
    clr();
    send(MK); send(FL); send(8'h00); send(8'h04); send(8'hA1); send(8'hA2);
    idle(TO);
    n_cmp++;
    if ({msg_err, rx_active} !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_early: got err=%b act=%b want 0 1", msg_err, rx_active);
    end
    idle(1);
    n_cmp++;
    if ({msg_err, err_code, rx_active} !== {1'b1, 2'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_err: got err=%b code=%0d act=%b want 1 3 0",
               msg_err, err_code, rx_active);
    end
    idle(2);
    n_cmp++;
    if (q_log.size() != 2 || mon_end != 0 || mon_err != 1) begin
      n_bad++;
      $display("FAIL timeout_pulses: bytes=%0d end=%0d err=%0d want 2 0 1",
               q_log.size(), mon_end, mon_err);
    end
    clr();
    send(MK); send(FL); send(8'h00); send(8'h02); send(8'hB1);
    idle(TO - 1);
    send(8'hB2);
    idle(1);
    n_cmp++;
    if ({msg_end, msg_err, q} !== {1'b1, 1'b0, 8'hB2}) begin
      n_bad++;
      $display("FAIL timeout_race: got end=%b err=%b q=%h want 1 0 B2", msg_end, msg_err, q);
    end
    idle(3);
    n_cmp++;
    if (mon_err != 0 || q_log.size() != 2) begin
      n_bad++;
      $display("FAIL timeout_race_quiet: err=%0d bytes=%0d want 0 2", mon_err, q_log.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    exp_b = '{8'h55, MK, 8'h66};
    clr();
    send(MK); send(FL); send(8'h00); send(8'h01); send(8'h55);
    send(MK); send(FL); send(8'h00); send(8'h02); send(MK); send(8'h66);
    idle(3);
    n_cmp++;
    if (mon_start != 2 || mon_end != 2 || mon_err != 0 || q_log.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_pulses: start=%0d end=%0d err=%0d bytes=%0d want 2 2 0 3",
               mon_start, mon_end, mon_err, q_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (q_log[i] !== exp_b[i]) begin
          n_bad++;
          $display("FAIL b2b_byte%0d: got %h want %h", i, q_log[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clr();
    send(MK); send(FL); send(8'h00); send(8'h04); send(8'hC1);
    idle(1);
    n_cmp++;
    if ({q_rdy, q, rx_active} !== {1'b1, 8'hC1, 1'b1}) begin
      n_bad++;
      $display("FAIL rstmid_pre: got q_rdy=%b q=%h act=%b want 1 C1 1", q_rdy, q, rx_active);
    end
    n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({q, q_rdy, msg_start, msg_end, msg_err, err_code, rx_active} !== 15'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h want 0",
               {q, q_rdy, msg_start, msg_end, msg_err, err_code, rx_active});
    end
    idle(2);
    @(negedge clk);
    n_rst = 1'b1;
    clr();
    idle(2);
    send(MK); send(FL); send(8'h00); send(8'h01); send(8'h5A);
    idle(3);
    n_cmp++;
    if (mon_err != 0 || mon_end != 1 || q_log.size() != 1 || end_q !== 8'h5A || err_code !== 2'd0) begin
      n_bad++;
      $display("FAIL rstmid_after: err=%0d end=%0d bytes=%0d last=%h code=%0d want 0 1 1 5A 0",
               mon_err, mon_end, q_log.size(), end_q, err_code);
    end
  endtask

`ifdef CCW_RX_ERR_CNT_EN
  task automatic test_err_cnt();
    @(negedge clk);
    n_rst = 1'b0;
    idle(2);
    n_rst = 1'b1;
    idle(1);
    n_cmp++;
    if (err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL errcnt_reset: got %0d want 0", err_cnt);
    end
    repeat (3) begin
      send(MK); send(8'h00);
    end
    idle(2);
    n_cmp++;
    if (err_cnt !== 8'd3) begin
      n_bad++;
      $display("FAIL errcnt_three: got %0d want 3", err_cnt);
    end
    repeat (297) begin
      send(MK); send(8'h00);
    end
    idle(2);
    n_cmp++;
    if (err_cnt !== 8'hFF) begin
      n_bad++;
      $display("FAIL errcnt_sat: got %h want FF", err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_noise();
    test_bad_flag();
    test_bad_len();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef CCW_RX_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
